// File: rtl/zigbee_tx_byte_fifo.sv
// rtl/zigbee_tx_byte_fifo.sv - APB-fed byte FIFO with LSB-first serialiser and bit-rate strobe
module zigbee_tx_byte_fifo #(
    parameter int DEPTH    = 64,
    parameter int RATE_DIV = 25
) (
    input  logic       clk,
    input  logic       reset_n,    // active-high asynchronous reset despite the name
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] pwdata,
    output logic       pready,
    output logic       pslverr,
    input  logic       en_IQ,
    output logic       data_out,
    output logic       IQ_rate,
    output logic       mem_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(RATE_DIV);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [7:0]     r_shift;
    logic [DW-1:0]  r_div;
    logic [2:0]     r_bit_idx;

    logic w_access;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_strobe;
    logic w_last_bit;

    // Full/empty come from the pre-edge count, so a write to a full FIFO is
    // refused even when a pop happens in the same cycle.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_access = psel & penable;
    assign w_push   = w_access & pwrite & ~w_full;

    assign pready    = w_access;
    assign pslverr   = w_access & (~pwrite | w_full);
    assign mem_state = w_full;

    // The strobe only fires while enabled, so pausing freezes the bit in place.
    assign w_strobe   = (r_state == S_SHIFT) & en_IQ & (r_div == DW'(RATE_DIV - 1));
    assign w_last_bit = w_strobe & (r_bit_idx == 3'd7);

    assign data_out = (r_state == S_SHIFT) & r_shift[r_bit_idx];
    assign IQ_rate  = w_strobe;

    // Serialiser state register.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pop decision; a byte may be reloaded straight after bit 7.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en_IQ && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte storage; no reset needed since only counted slots are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pwdata;
        end
    end

    // Circular pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Shift register load, rate divider and bit index.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_shift   <= '0;
            r_div     <= '0;
            r_bit_idx <= '0;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_div     <= '0;
            r_bit_idx <= '0;
        end else if (r_state == S_SHIFT && en_IQ) begin
            if (w_strobe) begin
                r_div     <= '0;
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_zigbee_tx_byte_fifo.sv
// tb/tb_zigbee_tx_byte_fifo.sv - directed self-checking bench for zigbee_tx_byte_fifo
module tb_zigbee_tx_byte_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] pwdata = 8'h00;
    logic       pready;
    logic       pslverr;
    logic       en_IQ = 1'b0;
    logic       data_out;
    logic       IQ_rate;
    logic       mem_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulses = 0;
    int dec_bits = 0;
    logic [7:0] dec_sr = 8'h00;
    logic [7:0] dec_q[$];
    int pulse_cyc[$];

    zigbee_tx_byte_fifo #(.DEPTH(64), .RATE_DIV(25)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .en_IQ    (en_IQ),
        .data_out (data_out),
        .IQ_rate  (IQ_rate),
        .mem_state(mem_state)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference bitstream decoder: rebuilds bytes LSB-first from strobed bits.
    always @(negedge clk) begin
        if (reset_n) begin
            dec_bits = 0;
        end else if (IQ_rate) begin
            pulses = pulses + 1;
            pulse_cyc.push_back(cyc);
            dec_sr = {data_out, dec_sr[7:1]};
            dec_bits = dec_bits + 1;
            if (dec_bits == 8) begin
                dec_q.push_back(dec_sr);
                dec_bits = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_access(input logic wr, input logic [7:0] b,
                              output logic rdy, output logic err, output int acc_cyc);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = wr; pwdata = b; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rdy = pready; err = pslverr; acc_cyc = cyc;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int k = 0; k < budget && dec_q.size() < n; k++) @(negedge clk);
    endtask

    initial begin
        logic rdy, err;
        int   acc, p0, p1, bad, changes, err_cnt;
        logic hold;
        logic [7:0] sent [64];

        // Reset then idle
        repeat (2) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_iq_rate", IQ_rate, 0);
        check("rst_mem_state", mem_state, 0);
        check("rst_pready", pready, 0);
        check("rst_pslverr", pslverr, 0);
        @(posedge clk); #1 reset_n = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (data_out !== 1'b0 || IQ_rate !== 1'b0 || mem_state !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_no_pops", dec_q.size() + pulses, 0);

        // Single byte 0xA5
        pulse_cyc.delete();
        p0 = pulses;
        @(posedge clk); #1 en_IQ = 1'b1;
        apb_access(1'b1, 8'hA5, rdy, err, acc);
        check("single_pslverr", err, 0);
        wait_bytes(1, 300);
        check("single_count", dec_q.size(), 1);
        if (dec_q.size() > 0) check("single_byte", dec_q[0], 8'hA5);
        check("single_pulses", pulses - p0, 8);
        if (pulse_cyc.size() > 0) check("single_latency", pulse_cyc[0] - acc, 26);
        bad = 0;
        for (int j = 1; j < pulse_cyc.size(); j++) if (pulse_cyc[j] - pulse_cyc[j-1] != 25) bad++;
        check("single_spacing", bad, 0);
        repeat (30) @(negedge clk);
        check("single_idle_pulses", pulses - p0, 8);
        check("single_idle_data", data_out, 0);

        // Paced stream of 64 random bytes
        dec_q.delete();
        @(posedge clk); #1 en_IQ = 1'b0;
        err_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            sent[i] = 8'($urandom_range(0, 255));
            apb_access(1'b1, sent[i], rdy, err, acc);
            if (err !== 1'b0) err_cnt++;
            if (i == 0) begin
                repeat (7) @(posedge clk);
                #1 en_IQ = 1'b1;
                repeat (990) @(posedge clk);
            end else begin
                repeat (997) @(posedge clk);
            end
        end
        wait_bytes(64, 400);
        check("paced_pslverr", err_cnt, 0);
        check("paced_count", dec_q.size(), 64);
        for (int i = 0; i < 64 && i < dec_q.size(); i++) check("paced_byte", dec_q[i], sent[i]);

        // Fill, read attempt, overflow
        dec_q.delete();
        @(posedge clk); #1 en_IQ = 1'b0;
        err_cnt = 0;
        for (int i = 0; i < 63; i++) begin
            apb_access(1'b1, 8'(i), rdy, err, acc);
            if (err !== 1'b0) err_cnt++;
        end
        check("fill_63_not_full", mem_state, 0);
        apb_access(1'b0, 8'h00, rdy, err, acc);
        check("read_pready", rdy, 1);
        check("read_pslverr", err, 1);
        @(negedge clk);
        check("read_count_kept", mem_state, 0);
        apb_access(1'b1, 8'd63, rdy, err, acc);
        if (err !== 1'b0) err_cnt++;
        check("fill_pslverr", err_cnt, 0);
        @(negedge clk);
        check("fill_64_full", mem_state, 1);
        apb_access(1'b1, 8'hEE, rdy, err, acc);
        check("ovf_pready", rdy, 1);
        check("ovf_pslverr", err, 1);
        check("ovf_still_full", mem_state, 1);
        @(posedge clk); #1 en_IQ = 1'b1;
        @(negedge clk);
        check("drain_pre_pop_full", mem_state, 1);
        @(negedge clk);
        check("drain_post_pop", mem_state, 0);
        wait_bytes(64, 64 * 200 + 200);
        repeat (300) @(negedge clk);
        check("drain_count", dec_q.size(), 64);
        for (int i = 0; i < 64 && i < dec_q.size(); i++) check("drain_byte", dec_q[i], 8'(i));

        // Pause mid-byte 0x3C
        dec_q.delete();
        p0 = pulses;
        apb_access(1'b1, 8'h3C, rdy, err, acc);
        for (int k = 0; k < 200 && pulses < p0 + 3; k++) @(negedge clk);
        repeat (10) @(posedge clk);
        #1 en_IQ = 1'b0;
        @(negedge clk);
        hold = data_out;
        p1 = pulses;
        changes = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (data_out !== hold || IQ_rate !== 1'b0) changes++;
        end
        check("pause_frozen", changes, 0);
        check("pause_no_pulses", pulses - p1, 0);
        check("pause_held_bit", hold, 1);
        @(posedge clk); #1 en_IQ = 1'b1;
        wait_bytes(1, 300);
        check("pause_count", dec_q.size(), 1);
        if (dec_q.size() > 0) check("pause_byte", dec_q[0], 8'h3C);

        // Reset mid-byte discards in-flight and stored data
        dec_q.delete();
        apb_access(1'b1, 8'hFF, rdy, err, acc);
        apb_access(1'b1, 8'h81, rdy, err, acc);
        repeat (40) @(negedge clk);
        check("pre_rst_data", data_out, 1);
        #2 reset_n = 1'b1;
        #1;
        check("async_rst_data", data_out, 0);
        check("async_rst_iq", IQ_rate, 0);
        @(posedge clk); #1 reset_n = 1'b0;
        p0 = pulses;
        repeat (450) @(negedge clk);
        check("rst_flush_bytes", dec_q.size(), 0);
        check("rst_flush_pulses", pulses - p0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/zigbee_tx_byte_fifo.md
Name: zigbee_tx_byte_fifo

Overview:
- Transmit-side byte buffer for the Zigbee baseband.
- Software pushes bytes over an APB write-only slave interface; the block stores them in a FIFO and serialises each byte LSB-first onto a 1-bit stream.
- Each bit is accompanied by a one-cycle rate strobe, which feeds the I/Q modulator.
- A downstream bitstream decoder rebuilds bytes from data_out sampled on IQ_rate.

Parameters:
- DEPTH, 64: FIFO capacity in bytes; must be a power of 2, at least 2.
- RATE_DIV, 25: clock cycles per serial bit (50 MHz / 25 = 2 Mbit/s); at least 2.

Ports:
- clk  in  1  system clock, 50 MHz, rising edge.
- reset_n  in  1  asynchronous reset, active-high: 1 = reset asserted (the name is kept for codebase consistency).
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB direction: 1 = write.
- pwdata  in  8  APB write byte.
- pready  out  1  APB ready.
- pslverr  out  1  APB error, valid while pready=1.
- en_IQ  in  1  serialiser enable.
- data_out  out  1  serial bit, LSB of each byte first.
- IQ_rate  out  1  one-cycle bit strobe; data_out is valid on its cycle.
- mem_state  out  1  FIFO full flag.

Behaviour:
- Reset (async, reset_n=1):
  - FIFO pointers and count = 0; shifter empty; bit counter, divider and bit index = 0.
  - Outputs: data_out=0, IQ_rate=0, mem_state=0, pslverr=0.
  - pready is combinational, so it is 0 whenever no access phase is active.
  - Reset asserted mid-transfer discards all stored and in-flight data.
- APB:
  - pready = psel & penable, combinational; zero wait states.
  - A write is accepted on a rising clk edge where psel & penable & pwrite & !full. pwdata is pushed at the tail and count increments.
  - pslverr = psel & penable & (!pwrite | full). The error covers reads (unsupported; there is no prdata) and writes to a full FIFO.
  - A rejected write does not change FIFO contents.
  - penable held high for N cycles with psel & pwrite performs N pushes, one per cycle.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0); mem_state = full, registered with count.
  - Push and pop in the same cycle: count is unchanged and both complete.
  - full is evaluated on the pre-edge count, so a write when full is rejected even if a pop occurs in that cycle.
- Serialiser states:
  - IDLE:
    - data_out=0, IQ_rate=0.
    - If en_IQ=1 and !empty: pop the head byte into an 8-bit shift register (one-cycle load), clear the divider and bit index, go to SHIFT.
  - SHIFT:
    - data_out = shift_reg[bit index], held for RATE_DIV cycles; the divider counts 0..RATE_DIV-1.
    - When divider == RATE_DIV-1: IQ_rate=1 for that single cycle; the bit index increments.
    - After bit 7's strobe, load the next byte if en_IQ & !empty. The next byte's bit 0 starts the following cycle, so the gap is at most 1 cycle; otherwise go to IDLE.
  - en_IQ=0 during SHIFT: divider and bit index freeze and IQ_rate=0, with data_out held. The byte resumes when en_IQ returns to 1, so the byte is never lost or truncated.
- Latency:
  - First byte written while IDLE with en_IQ=1: the load occurs 1 cycle after the push.
  - First IQ_rate follows RATE_DIV cycles after the load.
  - One byte occupies 8*RATE_DIV cycles (200 at default).
- Ordering: bytes leave in write order with no loss or duplication.

Test Plan:
- Reset then idle:
  - Hold reset_n=1 for 1 cycle, release; en_IQ=0.
  - data_out=0, IQ_rate=0, mem_state=0 throughout; no pops.
- Single byte:
  - Write 0xA5 with en_IQ=1.
  - Exactly 8 IQ_rate pulses, 25 cycles apart.
  - data_out at the pulses reads 1,0,1,0,0,1,0,1.
  - Decoder reconstructs 0xA5; then IDLE.
- Paced stream:
  - 64 random bytes, one per 1000 cycles; en_IQ rises at 200 ns.
  - All 64 decoded bytes match in order with no pslverr.
- Fill and overflow:
  - en_IQ=0; burst 64 writes 0..63, then 1 more write.
  - mem_state=1 after the 64th write.
  - The 65th write gets pready=1 and pslverr=1 and is dropped.
  - Enabling en_IQ then emits 0..63; mem_state falls after the first pop.
- APB read attempt: psel=1, pwrite=0, penable=1 gives pready=1 and pslverr=1, with FIFO count unchanged.
- Pause and reset:
  - Drop en_IQ for 100 cycles mid-byte 0x3C; the resumed output still decodes 0x3C.
  - Asserting reset mid-byte empties the FIFO and forces data_out=0 and IQ_rate=0 immediately.
